// File: rtl/simple_dp_ram.sv
// -----------------------------------------------------------------------------
// simple_dp_ram
//
// Simple dual-port synchronous RAM with one write port and one read port on a
// single clock. It holds the loop controller's per-loop iteration limits and
// its live iteration counters.
//
// Ports:
//   clk           sole clock; all state updates on the rising edge
//   reset         synchronous active-high reset; clears only the read register
//   s_write_addr  write address
//   s_write_req   write enable; commits s_write_data at s_write_addr
//   s_write_data  write data
//   s_read_addr   read address
//   s_read_req    read enable; loads mem[s_read_addr] into the read register
//   s_read_data   registered read data; holds its value between reads
//
// Read latency is one cycle. Throughput is one read and one write per cycle.
// A read and a write to the same address on the same edge are read-first, so
// the read returns the old contents.
// -----------------------------------------------------------------------------
module simple_dp_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_write_addr,
    input  logic                  s_write_req,
    input  logic [DATA_WIDTH-1:0] s_write_data,
    input  logic [ADDR_WIDTH-1:0] s_read_addr,
    input  logic                  s_read_req,
    output logic [DATA_WIDTH-1:0] s_read_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_read_data;

    // The array has no reset, so it maps onto block RAM. A write issued while
    // reset is high still commits; callers may load configuration during reset.
    always_ff @(posedge clk) begin
        if (s_write_req) begin
            r_mem[s_write_addr] <= s_write_data;
        end
    end

    // Both blocks sample r_mem with non-blocking semantics. A same-address,
    // same-edge read therefore sees the pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= '0;
        end else if (s_read_req) begin
            r_read_data <= r_mem[s_read_addr];
        end
    end

    assign s_read_data = r_read_data;

endmodule

// File: tb/tb_simple_dp_ram.sv
// -----------------------------------------------------------------------------
// tb_simple_dp_ram
//
// Directed test of simple_dp_ram with ADDR_WIDTH=5 and DATA_WIDTH=16.
// The driver applies one input vector per cycle and pushes the value it
// expects on s_read_data after that edge. A separate monitor pops one entry
// per edge and compares it with the DUT output.
// -----------------------------------------------------------------------------
module tb_simple_dp_ram;

    localparam int AW = 5;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] s_write_addr;
    logic          s_write_req;
    logic [DW-1:0] s_write_data;
    logic [AW-1:0] s_read_addr;
    logic          s_read_req;
    logic [DW-1:0] s_read_data;

    simple_dp_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_write_addr (s_write_addr),
        .s_write_req  (s_write_req),
        .s_write_data (s_write_data),
        .s_read_addr  (s_read_addr),
        .s_read_req   (s_read_req),
        .s_read_data  (s_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            chk;
        logic [DW-1:0] exp;
        string         name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: one scoreboard entry per clock edge, checked #1 after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.chk) begin
                    n_vec++;
                    if (s_read_data !== e.exp) begin
                        n_err++;
                        $display("FAIL %s: s_read_data=0x%04h expected=0x%04h",
                                 e.name, s_read_data, e.exp);
                    end else begin
                        $display("ok   %s: s_read_data=0x%04h", e.name, s_read_data);
                    end
                end
            end
        end
    end

    // Drive one cycle at the falling edge and queue the expected post-edge output.
    task automatic cyc(input bit rst,
                       input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit re, input logic [AW-1:0] ra,
                       input bit chk, input logic [DW-1:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        s_write_req  = we;
        s_write_addr = wa;
        s_write_data = wd;
        s_read_req   = re;
        s_read_addr  = ra;
        e.chk  = chk;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        s_write_req  = 1'b0;
        s_write_addr = '0;
        s_write_data = '0;
        s_read_req   = 1'b0;
        s_read_addr  = '0;

        // Reset for two cycles, then idle with no reads.
        cyc(1, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, "reset_0");
        cyc(1, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, "reset_1");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 16'h0000, 0, 5, 1, 16'h0000, "idle_zero");

        // Basic writes, including the top and bottom addresses.
        cyc(0, 1, 3,  16'h1234, 0, 0, 1, 16'h0000, "wr3_no_read");
        cyc(0, 1, 31, 16'hBEEF, 0, 0, 1, 16'h0000, "wr31_no_read");
        cyc(0, 1, 0,  16'h0001, 0, 0, 1, 16'h0000, "wr0_no_read");

        // Back-to-back reads.
        cyc(0, 0, 0, 16'h0000, 1, 3,  1, 16'h1234, "rd3");
        cyc(0, 0, 0, 16'h0000, 1, 31, 1, 16'hBEEF, "rd31");
        cyc(0, 0, 0, 16'h0000, 1, 0,  1, 16'h0001, "rd0");

        // Read hold: address changes while the request is low.
        cyc(0, 0, 0, 16'h0000, 1, 31, 1, 16'hBEEF, "rd31_again");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 16'h0000, 0, 3, 1, 16'hBEEF, "hold_beef");

        // Read-during-write to the same address returns the old data.
        cyc(0, 1, 7, 16'h00AA, 0, 3, 1, 16'hBEEF, "wr7_aa");
        cyc(0, 1, 7, 16'h00BB, 1, 7, 1, 16'h00AA, "rdw7_old");
        cyc(0, 0, 0, 16'h0000, 1, 7, 1, 16'h00BB, "rd7_new");

        // Simultaneous accesses to different addresses are independent.
        cyc(0, 1, 10, 16'h5555, 1, 3, 1, 16'h1234, "wr10_rd3_a");
        cyc(0, 1, 10, 16'h5555, 1, 3, 1, 16'h1234, "wr10_rd3_b");
        cyc(0, 0, 0,  16'h0000, 1, 10, 1, 16'h5555, "rd10");

        // Reset mid-operation overrides a read request; memory is retained.
        cyc(0, 0, 0,  16'h0000, 1, 7, 1, 16'h00BB, "rd7_pre_reset");
        cyc(1, 1, 12, 16'h0C0C, 1, 7, 1, 16'h0000, "reset_over_read");
        cyc(0, 0, 0,  16'h0000, 0, 7, 1, 16'h0000, "post_reset_hold");
        cyc(0, 0, 0,  16'h0000, 1, 7, 1, 16'h00BB, "rd7_retained");
        cyc(0, 0, 0,  16'h0000, 1, 12, 1, 16'h0C0C, "rd12_write_in_reset");
        cyc(0, 0, 0,  16'h0000, 1, 31, 1, 16'hBEEF, "rd31_final");

        // Drain the scoreboard with a bounded wait.
        #2;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
